i2c_slave: RTL and testbench

- I2C target that sits directly downstream of the bus master on the shared open-drain SCL/SDA lines.
- Oversamples SCL/SDA in the system clock domain and detects START, repeated START and STOP conditions.
- Matches a 7-bit address, then either receives write bytes and hands them to local logic, or shifts out local bytes on reads.
- Generates ACKs and releases SDA according to the I2C protocol.

---
 rtl/i2c_slave.sv | 172 +++++++++++++++++
 tb/tb_i2c_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match, byte write and read.
// Latency: bus events are seen 2-3 clk after the pins move; SDA changes one clk after a detected SCL fall.
// Backpressure: none; tx_data must be valid when tx_req pulses, rx_data holds until the next received byte.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       rw,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK} state_t;

   state_t     state, state_nxt;
   logic [2:0] scl_sync, sda_sync;
   logic       scl_q, scl_h, sda_q, sda_h;
   logic       scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
   logic [3:0] bit_cnt, cnt_nxt;
   logic [7:0] shreg, shreg_nxt, tx_shift, txsh_nxt, rx_data_nxt;
   logic       sda_oe, sda_oe_nxt, rx_valid_nxt, tx_req_nxt, rw_nxt, busy_nxt;

   assign sda = sda_oe ? 1'b0 : 1'bz;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync <= 3'b111;
         sda_sync <= 3'b111;
      end else begin
         scl_sync <= {scl_sync[1:0], scl};
         sda_sync <= {sda_sync[1:0], sda};
      end
   end

   assign scl_q    = scl_sync[1];
   assign scl_h    = scl_sync[2];
   assign sda_q    = sda_sync[1];
   assign sda_h    = sda_sync[2];
   assign scl_rise = scl_q & ~scl_h;
   assign scl_fall = ~scl_q & scl_h;
   assign sda_rise = sda_q & ~sda_h;
   assign sda_fall = ~sda_q & sda_h;
   // SCL must be high on both samples, so an SDA edge coinciding with an SCL rise counts as data
   assign start_det = sda_fall & scl_q & scl_h;
   assign stop_det  = sda_rise & scl_q & scl_h;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         shreg    <= 8'd0;
         tx_shift <= 8'd0;
         sda_oe   <= 1'b0;
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         rw       <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= cnt_nxt;
         shreg    <= shreg_nxt;
         tx_shift <= txsh_nxt;
         sda_oe   <= sda_oe_nxt;
         rx_data  <= rx_data_nxt;
         rx_valid <= rx_valid_nxt;
         tx_req   <= tx_req_nxt;
         rw       <= rw_nxt;
         busy     <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = bit_cnt;
      shreg_nxt    = shreg;
      txsh_nxt     = tx_shift;
      sda_oe_nxt   = sda_oe;
      rx_data_nxt  = rx_data;
      rx_valid_nxt = 1'b0;
      tx_req_nxt   = 1'b0;
      rw_nxt       = rw;
      busy_nxt     = busy;
      if (start_det) begin
         state_nxt  = ADDR;
         cnt_nxt    = 4'd0;
         sda_oe_nxt = 1'b0;
         busy_nxt   = 1'b0;
      end else if (stop_det) begin
         state_nxt  = IDLE;
         cnt_nxt    = 4'd0;
         sda_oe_nxt = 1'b0;
         busy_nxt   = 1'b0;
      end else begin
         case (state)
            IDLE: ;
            ADDR, WDATA: begin
               if (scl_rise) begin
                  shreg_nxt = {shreg[6:0], sda_q};
                  cnt_nxt   = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  cnt_nxt = 4'd0;
                  if (state == ADDR) begin
                     if (shreg[7:1] == SLAVE_ADDR) begin
                        rw_nxt     = shreg[0];
                        busy_nxt   = 1'b1;
                        sda_oe_nxt = 1'b1;
                        state_nxt  = ADDR_ACK;
                     end else begin
                        state_nxt = IDLE;
                     end
                  end else begin
                     rx_data_nxt  = shreg;
                     rx_valid_nxt = 1'b1;
                     sda_oe_nxt   = 1'b1;
                     state_nxt    = WACK;
                  end
               end
            end
            ADDR_ACK, WACK: begin
               if (scl_fall) begin
                  cnt_nxt = 4'd0;
                  if (state == ADDR_ACK && rw) begin
                     txsh_nxt   = tx_data;
                     tx_req_nxt = 1'b1;
                     sda_oe_nxt = ~tx_data[7];
                     state_nxt  = RDATA;
                  end else begin
                     sda_oe_nxt = 1'b0;
                     state_nxt  = WDATA;
                  end
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  cnt_nxt = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     cnt_nxt    = 4'd0;
                     sda_oe_nxt = 1'b0;
                     state_nxt  = RACK;
                  end else begin
                     txsh_nxt   = {tx_shift[6:0], 1'b0};
                     sda_oe_nxt = ~tx_shift[6];
                  end
               end
            end
            RACK: begin
               // A fall is only reached here after the master ACKed on the preceding rise
               if (scl_rise && sda_q) begin
                  busy_nxt  = 1'b0;
                  state_nxt = IDLE;
               end else if (scl_fall) begin
                  cnt_nxt    = 4'd0;
                  txsh_nxt   = tx_data;
                  tx_req_nxt = 1'b1;
                  sda_oe_nxt = ~tx_data[7];
                  state_nxt  = RDATA;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level bus master, table of directed transactions, randomized transactions
// against a transaction-level model, plus repeated-START and reset-mid-read sequences.
module tb_i2c_slave;
   logic       clk, reset, scl, m_sda_low;
   logic [7:0] tx_data, rx_data;
   logic       rx_valid, tx_req, rw, busy;
   wire        sda;

   assign sda = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
      .clk(clk), .reset(reset), .scl(scl), .sda(sda), .tx_data(tx_data),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .rw(rw), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rx_cnt = 0, tx_cnt = 0, drv_cnt = 0, pulse_err = 0;
   logic [7:0] rx_log [$];
   logic rxv_d = 1'b0, txr_d = 1'b0;

   always @(posedge clk) begin
      #2;
      if (!reset) begin
         if (rx_valid) begin
            rx_cnt++;
            rx_log.push_back(rx_data);
         end
         if (tx_req) tx_cnt++;
         if ((rx_valid && tx_req) || (rx_valid && rxv_d) || (tx_req && txr_d)) pulse_err++;
         if (sda === 1'b0 && !m_sda_low) drv_cnt++;
      end
      rxv_d = rx_valid;
      txr_d = tx_req;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [6:0]      a;
      logic            r;
      int              n;
      logic [2:0][7:0] d;
      logic            e_aack;
      logic [2:0]      e_acks;
      logic [2:0][7:0] e_rd;
      logic            e_busy;
      int              e_nrx;
      int              e_ntx;
      logic [2:0][7:0] e_rxv;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_cyc(input logic drv_low, output logic seen);
      m_sda_low = drv_low;
      clks(5);
      scl = 1'b1;
      clks(5);
      seen = sda;
      clks(5);
      scl = 1'b0;
      clks(5);
   endtask

   task automatic send_start();
      if (!scl) begin
         m_sda_low = 1'b0;
         clks(5);
         scl = 1'b1;
         clks(5);
      end
      m_sda_low = 1'b1;
      clks(5);
      scl = 1'b0;
      clks(5);
   endtask

   task automatic send_stop();
      m_sda_low = 1'b1;
      clks(5);
      scl = 1'b1;
      clks(5);
      m_sda_low = 1'b0;
      clks(10);
   endtask

   task automatic wr_byte(input logic [7:0] v, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cyc(~v[i], s);
      bit_cyc(1'b0, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] v);
      logic b;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         bit_cyc(1'b0, b);
         v = {v[6:0], b};
      end
      bit_cyc(~nack, b);
   endtask

   task automatic do_txn(input string tag, input vec_t t);
      int rx0, tx0, dv0, pe0;
      logic aack, k, bmid, rwmid;
      logic [2:0] acks;
      logic [2:0][7:0] rd, rxv;
      logic [7:0] g;
      rx0 = rx_cnt; tx0 = tx_cnt; dv0 = drv_cnt; pe0 = pulse_err;
      acks = '1; rd = '1; rxv = '0;
      tx_data = t.d[0];
      send_start();
      wr_byte({t.a, t.r}, aack);
      bmid = busy;
      rwmid = rw;
      for (int i = 0; i < t.n; i++) begin
         if (t.r) begin
            tx_data = (i + 1 < t.n) ? t.d[i+1] : 8'h00;
            rd_byte(i == t.n - 1, g);
            rd[i] = g;
         end else begin
            wr_byte(t.d[i], k);
            acks[i] = k;
         end
      end
      send_stop();
      for (int i = 0; i < rx_cnt - rx0 && i < 3; i++) rxv[i] = rx_log[rx0 + i];
      chk({tag, " addr_ack"}, 32'(aack), 32'(t.e_aack));
      chk({tag, " data_acks"}, 32'(acks), 32'(t.e_acks));
      chk({tag, " read_data"}, 32'(rd), 32'(t.e_rd));
      chk({tag, " busy_mid"}, 32'(bmid), 32'(t.e_busy));
      if (t.e_busy) chk({tag, " rw"}, 32'(rwmid), 32'(t.r));
      chk({tag, " rx_valid_count"}, 32'(rx_cnt - rx0), 32'(t.e_nrx));
      chk({tag, " rx_data"}, 32'(rxv), 32'(t.e_rxv));
      chk({tag, " tx_req_count"}, 32'(tx_cnt - tx0), 32'(t.e_ntx));
      chk({tag, " sda_driven"}, 32'(drv_cnt != dv0), 32'(t.e_busy));
      chk({tag, " busy_after_stop"}, 32'(busy), 32'd0);
      chk({tag, " pulse_shape"}, 32'(pulse_err - pe0), 32'd0);
   endtask

   vec_t tbl [6];
   vec_t rv;

   initial begin
      logic k, s, hit;
      logic [7:0] g;
      int rx0, tx0;

      tbl[0] = '{7'h42, 1'b0, 1, 24'h0000A5, 1'b0, 3'b110, 24'hFFFFFF, 1'b1, 1, 0, 24'h0000A5};
      tbl[1] = '{7'h42, 1'b1, 1, 24'h00003C, 1'b0, 3'b111, 24'hFFFF3C, 1'b1, 0, 1, 24'h000000};
      tbl[2] = '{7'h17, 1'b0, 1, 24'h0000FF, 1'b1, 3'b111, 24'hFFFFFF, 1'b0, 0, 0, 24'h000000};
      tbl[3] = '{7'h42, 1'b0, 2, 24'h002211, 1'b0, 3'b100, 24'hFFFFFF, 1'b1, 2, 0, 24'h002211};
      tbl[4] = '{7'h00, 1'b0, 1, 24'h000055, 1'b1, 3'b111, 24'hFFFFFF, 1'b0, 0, 0, 24'h000000};
      tbl[5] = '{7'h42, 1'b1, 3, 24'hFE0081, 1'b0, 3'b111, 24'hFE0081, 1'b1, 0, 3, 24'h000000};

      reset = 1'b1; scl = 1'b1; m_sda_low = 1'b0; tx_data = 8'h00;
      clks(3);
      chk("reset sda_released", 32'(sda), 32'd1);
      chk("reset outputs", 32'({rx_data, rx_valid, tx_req, rw, busy}), 32'd0);
      reset = 1'b0;
      clks(5);

      for (int i = 0; i < 6; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

      // Randomized transactions against a transaction-level expectation
      for (int j = 0; j < 16; j++) begin
         rv.a = ($urandom_range(0, 1) != 0) ? 7'h42 : 7'($urandom_range(0, 127));
         rv.r = 1'($urandom_range(0, 1));
         rv.n = int'($urandom_range(1, 3));
         rv.d = 24'($urandom);
         hit = (rv.a == 7'h42);
         rv.e_aack = !hit;
         rv.e_acks = '1; rv.e_rd = '1; rv.e_rxv = '0;
         for (int i = 0; i < rv.n; i++) begin
            if (rv.r) rv.e_rd[i] = hit ? rv.d[i] : 8'hFF;
            else begin
               rv.e_acks[i] = !hit;
               if (hit) rv.e_rxv[i] = rv.d[i];
            end
         end
         rv.e_busy = hit;
         rv.e_nrx = (!rv.r && hit) ? rv.n : 0;
         rv.e_ntx = (rv.r && hit) ? rv.n : 0;
         do_txn($sformatf("rnd%0d", j), rv);
      end

      // Partial write byte, repeated START, then a two-byte read
      rx0 = rx_cnt; tx0 = tx_cnt;
      tx_data = 8'h5A;
      send_start();
      wr_byte({7'h42, 1'b0}, k);
      chk("rs addr_ack_w", 32'(k), 32'd0);
      for (int i = 0; i < 4; i++) bit_cyc(i % 2 == 0, s);
      send_start();
      wr_byte({7'h42, 1'b1}, k);
      chk("rs addr_ack_r", 32'(k), 32'd0);
      chk("rs rw", 32'(rw), 32'd1);
      tx_data = 8'hC3;
      rd_byte(1'b0, g);
      chk("rs byte0", 32'(g), 32'h5A);
      tx_data = 8'h00;
      rd_byte(1'b1, g);
      chk("rs byte1", 32'(g), 32'hC3);
      send_stop();
      chk("rs rx_valid_count", 32'(rx_cnt - rx0), 32'd0);
      chk("rs tx_req_count", 32'(tx_cnt - tx0), 32'd2);

      // Reset while the target drives a 0 data bit
      tx_data = 8'h3C;
      send_start();
      wr_byte({7'h42, 1'b1}, k);
      chk("rst target_drives_bit7", 32'(sda), 32'd0);
      reset = 1'b1;
      #1;
      chk("rst sda_released", 32'(sda), 32'd1);
      chk("rst outputs", 32'({rx_data, rx_valid, tx_req, rw, busy}), 32'd0);
      clks(3);
      reset = 1'b0;
      clks(3);
      send_stop();
      rv = '{7'h42, 1'b0, 1, 24'h000066, 1'b0, 3'b110, 24'hFFFFFF, 1'b1, 1, 0, 24'h000066};
      do_txn("post_reset", rv);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
